// File: rtl/vga_pattern_sequencer_if.sv
// Control/status bundle between the timing/key front end and the pattern sequencer.
interface vga_pattern_sequencer_if;
    localparam int unsigned PAT_W = 2;

    logic             key_pulse;
    logic             frame_start;
    logic             auto_en;
    logic [PAT_W-1:0] pattern_sel;
    logic             blank;
    logic             switch_done;
    logic             busy;

    // Master drives requests and frame timing, observes sequencer status.
    modport master (
        output key_pulse, frame_start, auto_en,
        input  pattern_sel, blank, switch_done, busy
    );

    // Slave is the sequencer itself.
    modport slave (
        input  key_pulse, frame_start, auto_en,
        output pattern_sel, blank, switch_done, busy
    );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer: switches the active pattern only at frame
// boundaries, with a forced-blank window of whole frames around each change.
module vga_pattern_sequencer #(
    parameter int unsigned NUM_PATTERNS = 3,
    parameter int unsigned DWELL_FRAMES = 120,
    parameter int unsigned BLANK_FRAMES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    vga_pattern_sequencer_if.slave  bus
);
    localparam int unsigned PAT_W   = 2;
    localparam int unsigned DWELL_W = 12;
    localparam int unsigned BLANK_W = 4;

    typedef enum logic [1:0] {
        SHOW  = 2'd0,
        ARM   = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PAT_W-1:0]     pattern_q, pattern_d;
    logic                 blank_q, blank_d;
    logic                 switch_q, switch_d;
    logic                 busy_q, busy_d;
    logic                 pend_q, pend_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic                 dwell_exp_c;
    logic                 change_req_c;

    // Dwell expiry is same-cycle with the frame_start that completes the dwell.
    assign dwell_exp_c  = (state_q == SHOW) && bus.auto_en && bus.frame_start &&
                          (dwell_q == DWELL_W'(DWELL_FRAMES - 1));
    assign change_req_c = bus.key_pulse || dwell_exp_c || pend_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        pend_d      = pend_q;
        dwell_d     = dwell_q;
        blank_cnt_d = blank_cnt_q;
        switch_d    = 1'b0;

        unique case (state_q)
            SHOW: begin
                if (!bus.auto_en) begin
                    dwell_d = '0;
                end else if (bus.frame_start) begin
                    dwell_d = dwell_exp_c ? '0 : dwell_q + DWELL_W'(1);
                end
                if (change_req_c) begin
                    state_d = ARM;
                    pend_d  = 1'b0;
                    dwell_d = '0;
                end
            end
            ARM: begin
                dwell_d = '0;
                if (bus.key_pulse) pend_d = 1'b1;
                if (bus.frame_start) begin
                    state_d     = BLANK;
                    blank_cnt_d = BLANK_W'(BLANK_FRAMES - 1);
                end
            end
            BLANK: begin
                dwell_d = '0;
                if (bus.key_pulse) pend_d = 1'b1;
                if (bus.frame_start) begin
                    if (blank_cnt_q != '0) begin
                        blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                    end else begin
                        state_d   = SHOW;
                        switch_d  = 1'b1;
                        pattern_d = (pattern_q == PAT_W'(NUM_PATTERNS - 1)) ?
                                    '0 : pattern_q + PAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = SHOW;
                dwell_d = '0;
            end
        endcase

        blank_d = (state_d == BLANK);
        busy_d  = (state_d != SHOW);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= SHOW;
            pattern_q   <= '0;
            blank_q     <= 1'b0;
            switch_q    <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            dwell_q     <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            blank_q     <= blank_d;
            switch_q    <= switch_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            dwell_q     <= dwell_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign bus.pattern_sel = pattern_q;
    assign bus.blank       = blank_q;
    assign bus.switch_done = switch_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer with a 100-cycle frame period.
module tb_vga_pattern_sequencer;
    localparam int FP = 100;

    logic CLK = 1'b0;
    logic RESET;
    int   cyc;
    int   sd_cnt;
    int   checks;
    int   failures;

    vga_pattern_sequencer_if bus ();

    vga_pattern_sequencer #(
        .NUM_PATTERNS (3),
        .DWELL_FRAMES (3),
        .BLANK_FRAMES (2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Drive one cycle (frame_start on multiples of FP), then sample #1 after the edge.
    task automatic tick(input logic k);
        bus.key_pulse   = k;
        bus.frame_start = (cyc != 0) && (cyc % FP == 0);
        @(posedge CLK);
        #1;
        cyc++;
        bus.key_pulse   = 1'b0;
        bus.frame_start = 1'b0;
        if (bus.switch_done) sd_cnt++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick(1'b0);
    endtask

    task automatic align10();
        while (cyc % FP != 10) tick(1'b0);
    endtask

    // Press a key 10 cycles into a frame and wait (bounded) for the switch.
    task automatic key_change(input int exp_pat);
        int kc;
        int n;
        align10();
        kc = cyc;
        tick(1'b1);
        n = 0;
        while (!bus.switch_done && n < 500) begin
            tick(1'b0);
            n++;
        end
        check("kc_sw_time", cyc, (kc / FP + 3) * FP + 1);
        check("kc_pattern", int'(bus.pattern_sel), exp_pat);
    endtask

    initial begin
        int k;
        int sd0;
        checks   = 0;
        failures = 0;
        sd_cnt   = 0;
        cyc      = 0;
        RESET    = 1'b0;
        bus.key_pulse   = 1'b0;
        bus.frame_start = 1'b0;
        bus.auto_en     = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_pattern", int'(bus.pattern_sel), 0);
        check("rst_blank",   int'(bus.blank), 0);
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_switch",  int'(bus.switch_done), 0);

        @(negedge CLK) RESET = 1'b1;
        @(posedge CLK);
        #1;
        cyc = 0;

        // Single key at cycle 10
        run_to(10);
        tick(1'b1);
        check("key_busy",  int'(bus.busy), 1);
        check("key_blank", int'(bus.blank), 0);
        run_to(100);
        check("pre_blank", int'(bus.blank), 0);
        tick(1'b0);
        check("blank_on_101", int'(bus.blank), 1);
        run_to(300);
        check("blank_hold",   int'(bus.blank), 1);
        check("pattern_hold", int'(bus.pattern_sel), 0);
        check("switch_early", int'(bus.switch_done), 0);
        tick(1'b0);
        check("switch_301",  int'(bus.switch_done), 1);
        check("pattern_301", int'(bus.pattern_sel), 1);
        check("blank_off",   int'(bus.blank), 0);
        check("busy_off",    int'(bus.busy), 0);
        tick(1'b0);
        check("switch_pulse", int'(bus.switch_done), 0);

        // Wrap 1 -> 2 -> 0
        key_change(2);
        key_change(0);

        // Three pulses during one BLANK collapse into one pending change
        align10();
        k   = cyc;
        sd0 = sd_cnt;
        tick(1'b1);
        run_to(k + 140);
        check("q_in_blank", int'(bus.blank), 1);
        tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
        run_to(k + 292);
        check("q_rearm", int'(bus.busy), 1);
        run_to(k + 700);
        check("q_switches", sd_cnt - sd0, 2);
        check("q_pattern",  int'(bus.pattern_sel), 2);

        // Auto advance after three frames in SHOW
        align10();
        k   = cyc;
        sd0 = sd_cnt;
        bus.auto_en = 1'b1;
        run_to(k + 290);
        check("auto_pre", int'(bus.busy), 0);
        tick(1'b0);
        check("auto_arm", int'(bus.busy), 1);
        run_to(k + 591);
        check("auto_switch",  int'(bus.switch_done), 1);
        check("auto_pattern", int'(bus.pattern_sel), 0);
        run_to(k + 800);
        bus.auto_en = 1'b0;
        run_to(k + 1300);
        check("auto_off_sw",  sd_cnt - sd0, 1);
        check("auto_off_pat", int'(bus.pattern_sel), 0);
        check("auto_off_busy", int'(bus.busy), 0);

        // Key coincident with dwell expiry and frame_start
        align10();
        k   = cyc;
        sd0 = sd_cnt;
        bus.auto_en = 1'b1;
        run_to(k + 290);
        tick(1'b1);
        check("coll_arm", int'(bus.busy), 1);
        run_to(k + 300);
        check("coll_no_blank", int'(bus.blank), 0);
        run_to(k + 391);
        check("coll_blank", int'(bus.blank), 1);
        run_to(k + 591);
        check("coll_switch", int'(bus.switch_done), 1);
        bus.auto_en = 1'b0;
        run_to(k + 900);
        check("coll_count",   sd_cnt - sd0, 1);
        check("coll_pattern", int'(bus.pattern_sel), 1);

        // Asynchronous reset mid-BLANK, then first request after release
        align10();
        k = cyc;
        tick(1'b1);
        run_to(k + 150);
        check("rb_blank", int'(bus.blank), 1);
        RESET = 1'b0;
        #2;
        check("rb_pattern", int'(bus.pattern_sel), 0);
        check("rb_blank0",  int'(bus.blank), 0);
        check("rb_busy0",   int'(bus.busy), 0);
        #1;
        RESET = 1'b1;
        tick(1'b1);
        check("rel_req_busy", int'(bus.busy), 1);
        check("rel_pattern",  int'(bus.pattern_sel), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
